// File: rtl/fadd_align_ctrl.sv
// Alignment-stage sequencer for the half-precision adder: orders the operands,
// drives the shared right barrel shifter and hands aligned mantissas downstream.
module fadd_align_ctrl #(
  parameter int unsigned EXP_W  = 5,
  parameter int unsigned FRAC_W = 10,
  parameter int unsigned SEL_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   a,
  input  logic [EXP_W+FRAC_W:0]   b,
  output logic [FRAC_W:0]         sh_in,
  output logic [SEL_W-1:0]        sh_sel,
  input  logic [FRAC_W:0]         sh_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W-1:0]        exp_big,
  output logic [FRAC_W:0]         mant_big,
  output logic [FRAC_W:0]         mant_small,
  output logic                    sign_big,
  output logic                    sign_small,
  output logic                    swapped,
  output logic                    sticky,
  output logic                    busy
);

  localparam int unsigned MANT_W = FRAC_W + 1;
  localparam int unsigned OP_W   = 1 + EXP_W + FRAC_W;
  localparam int unsigned MAX_SH = (1 << SEL_W) - 1;

  typedef enum logic [1:0] {IDLE, CMP, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [OP_W-1:0]     a_q, a_d, b_q, b_d;
  logic [EXP_W-1:0]    exp_big_q, exp_big_d;
  logic [MANT_W-1:0]   mant_big_q, mant_big_d;
  logic [MANT_W-1:0]   mant_small_q, mant_small_d;
  logic [MANT_W-1:0]   small_pre_q, small_pre_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                sign_big_q, sign_big_d;
  logic                sign_small_q, sign_small_d;
  logic                swapped_q, swapped_d;
  logic                sticky_q, sticky_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;

  logic [EXP_W-1:0]    exp_a, exp_b, eexp_a, eexp_b, eexp_bg, eexp_sm, diff;
  logic [MANT_W-1:0]   mant_a, mant_b, mant_bg, mant_sm, lost_mask;
  logic                a_big, sel_sign_bg, sel_sign_sm, sticky_c;
  logic [SEL_W-1:0]    sel_c;

  // Operand decode and ordering from the captured pair; denormals use exponent 1.
  always_comb begin
    exp_a   = a_q[OP_W-2 -: EXP_W];
    exp_b   = b_q[OP_W-2 -: EXP_W];
    mant_a  = {|exp_a, a_q[FRAC_W-1:0]};
    mant_b  = {|exp_b, b_q[FRAC_W-1:0]};
    eexp_a  = (exp_a == '0) ? EXP_W'(1) : exp_a;
    eexp_b  = (exp_b == '0) ? EXP_W'(1) : exp_b;
    a_big   = (eexp_a > eexp_b) || ((eexp_a == eexp_b) && (mant_a >= mant_b));
    eexp_bg = a_big ? eexp_a : eexp_b;
    eexp_sm = a_big ? eexp_b : eexp_a;
    mant_bg = a_big ? mant_a : mant_b;
    mant_sm = a_big ? mant_b : mant_a;
    sel_sign_bg = a_big ? a_q[OP_W-1] : b_q[OP_W-1];
    sel_sign_sm = a_big ? b_q[OP_W-1] : a_q[OP_W-1];
    diff    = eexp_bg - eexp_sm;
    sel_c   = (diff > EXP_W'(MAX_SH)) ? SEL_W'(MAX_SH) : SEL_W'(diff);
    // Bits that fall off the bottom of the shifter; whole mantissa once diff >= width.
    if (diff >= EXP_W'(MANT_W)) lost_mask = '1;
    else                        lost_mask = (MANT_W'(1) << diff) - MANT_W'(1);
    sticky_c = |(mant_sm & lost_mask);
  end

  // Next-state and datapath capture.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    exp_big_d    = exp_big_q;
    mant_big_d   = mant_big_q;
    mant_small_d = mant_small_q;
    small_pre_d  = small_pre_q;
    sel_d        = sel_q;
    sign_big_d   = sign_big_q;
    sign_small_d = sign_small_q;
    swapped_d    = swapped_q;
    sticky_d     = sticky_q;
    sh_in        = '0;
    sh_sel       = '0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          state_d = CMP;
        end
      end
      CMP: begin
        exp_big_d    = eexp_bg;
        mant_big_d   = mant_bg;
        small_pre_d  = mant_sm;
        sel_d        = sel_c;
        sign_big_d   = sel_sign_bg;
        sign_small_d = sel_sign_sm;
        swapped_d    = ~a_big;
        sticky_d     = sticky_c;
        state_d      = SHIFT;
      end
      SHIFT: begin
        sh_in        = small_pre_q;
        sh_sel       = sel_q;
        mant_small_d = sh_out;
        state_d      = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      exp_big_q    <= '0;
      mant_big_q   <= '0;
      mant_small_q <= '0;
      small_pre_q  <= '0;
      sel_q        <= '0;
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      swapped_q    <= 1'b0;
      sticky_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      exp_big_q    <= exp_big_d;
      mant_big_q   <= mant_big_d;
      mant_small_q <= mant_small_d;
      small_pre_q  <= small_pre_d;
      sel_q        <= sel_d;
      sign_big_q   <= sign_big_d;
      sign_small_q <= sign_small_d;
      swapped_q    <= swapped_d;
      sticky_q     <= sticky_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign in_ready   = (state_q == IDLE) & ~rst;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign exp_big    = exp_big_q;
  assign mant_big   = mant_big_q;
  assign mant_small = mant_small_q;
  assign sign_big   = sign_big_q;
  assign sign_small = sign_small_q;
  assign swapped    = swapped_q;
  assign sticky     = sticky_q;

endmodule

// File: tb/tb_fadd_align_ctrl.sv
// Scoreboard bench for fadd_align_ctrl: directed cases plus random operand pairs
// with random downstream backpressure, checked against an arithmetic reference.
module tb_fadd_align_ctrl;

  typedef struct {
    logic [4:0]  e;
    logic [10:0] mb;
    logic [10:0] ms;
    logic        sb;
    logic        ss;
    logic        sw;
    logic        st;
    logic [3:0]  sel;
    logic [10:0] shin;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [10:0] sh_in;
  logic [3:0]  sh_sel;
  logic [10:0] sh_out;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  exp_big;
  logic [10:0] mant_big;
  logic [10:0] mant_small;
  logic        sign_big;
  logic        sign_small;
  logic        swapped;
  logic        sticky;
  logic        busy;

  int   total = 0;
  int   bad = 0;
  bit   rand_bp = 1'b0;
  exp_t q[$];

  always #5 clk = ~clk;

  // Behavioural barrel shifter standing in for the shared instance.
  assign sh_out = sh_in >> sh_sel;

  fadd_align_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sh_in(sh_in), .sh_sel(sh_sel), .sh_out(sh_out),
    .out_valid(out_valid), .out_ready(out_ready), .exp_big(exp_big),
    .mant_big(mant_big), .mant_small(mant_small), .sign_big(sign_big),
    .sign_small(sign_small), .swapped(swapped), .sticky(sticky), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y);
    exp_t r;
    int ex = int'(x[14:10]);
    int ey = int'(y[14:10]);
    int mx = (ex != 0 ? 1024 : 0) + int'(x[9:0]);
    int my = (ey != 0 ? 1024 : 0) + int'(y[9:0]);
    int eex = (ex == 0) ? 1 : ex;
    int eey = (ey == 0) ? 1 : ey;
    bit xbig = (eex > eey) || (eex == eey && mx >= my);
    int eb = xbig ? eex : eey;
    int es = xbig ? eey : eex;
    int mb = xbig ? mx : my;
    int ms = xbig ? my : mx;
    int d = eb - es;
    int keep = (d < 11) ? d : 11;
    r.e    = 5'(eb);
    r.mb   = 11'(mb);
    r.ms   = 11'(ms >> d);
    r.sb   = xbig ? x[15] : y[15];
    r.ss   = xbig ? y[15] : x[15];
    r.sw   = !xbig;
    r.st   = (ms % (1 << keep)) != 0;
    r.sel  = 4'((d > 15) ? 15 : d);
    r.shin = 11'(ms);
    return r;
  endfunction

  // Monitor: idle shifter invariants and scoreboard compare on each output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!busy) begin
      chk("idle_sh_sel", 32'(sh_sel), 32'd0);
      chk("idle_sh_in", 32'(sh_in), 32'd0);
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output exp_big=%0h mant_small=%0h at %0t", exp_big, mant_small, $time);
      end else begin
        e = q.pop_front();
        chk("exp_big", 32'(exp_big), 32'(e.e));
        chk("mant_big", 32'(mant_big), 32'(e.mb));
        chk("mant_small", 32'(mant_small), 32'(e.ms));
        chk("sign_big", 32'(sign_big), 32'(e.sb));
        chk("sign_small", 32'(sign_small), 32'(e.ss));
        chk("swapped", 32'(swapped), 32'(e.sw));
        chk("sticky", 32'(sticky), 32'(e.st));
      end
    end
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Issue one pair; returns at the negedge of the first out_valid cycle.
  task automatic send(input logic [15:0] av, input logic [15:0] bv);
    exp_t e = model(av, bv);
    int   n = 0;
    bit   ok = 1'b0;
    @(posedge clk);
    #1;
    a = av;
    b = bv;
    in_valid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      n++;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout a=%0h b=%0h", av, bv);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    q.push_back(e);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("shift_sel", 32'(sh_sel), 32'(e.sel));
    chk("shift_in", 32'(sh_in), 32'(e.shin));
    chk("ov_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("ov_rise", 32'(out_valid), 32'd1);
    chk("ready_in_done", 32'(in_ready), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    logic [10:0] hold_ms, hold_mb;
    logic [4:0]  hold_e;
    int          n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_exp_big", 32'(exp_big), 32'd0);
    chk("rst_mant_small", 32'(mant_small), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Basic ordering, swap, sticky and clamp cases.
    send(16'h3C00, 16'h3800);
    chk("t1_exp_big", 32'(exp_big), 32'd15);
    chk("t1_mant_big", 32'(mant_big), 32'h400);
    chk("t1_mant_small", 32'(mant_small), 32'h200);
    @(negedge clk);
    chk("t1_ready_back", 32'(in_ready), 32'd1);
    send(16'h3800, 16'h3C01);
    chk("t2_swapped", 32'(swapped), 32'd1);
    send(16'h3C00, 16'h3801);
    chk("t2_sticky", 32'(sticky), 32'd1);
    send(16'h3C01, 16'h3C02);
    chk("t3_mant_small", 32'(mant_small), 32'h401);
    send(16'h3C00, 16'h0001);
    chk("t4_sticky", 32'(sticky), 32'd1);
    send(16'h7800, 16'h0401);
    chk("t4_exp_big", 32'(exp_big), 32'd30);
    send(16'h8000, 16'h0000);
    send(16'hFC00, 16'h7C00);

    // Backpressure with a new pair waiting.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(16'h4A00, 16'hC5FF);
    hold_ms = mant_small;
    hold_mb = mant_big;
    hold_e  = exp_big;
    a = 16'h3555;
    b = 16'h4123;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_mant_small", 32'(mant_small), 32'(hold_ms));
      chk("bp_mant_big", 32'(mant_big), 32'(hold_mb));
      chk("bp_exp_big", 32'(exp_big), 32'(hold_e));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(16'h3555, 16'h4123);

    // Reset during SHIFT discards the pair.
    @(posedge clk);
    #1;
    a = 16'h4000;
    b = 16'h3555;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_in_ready_rst", 32'(in_ready), 32'd0);
    chk("abort_busy_shift", 32'(busy), 32'd1);
    @(negedge clk);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_exp_big", 32'(exp_big), 32'd0);
    chk("abort_mant_big", 32'(mant_big), 32'd0);
    chk("abort_mant_small", 32'(mant_small), 32'd0);
    chk("abort_flags", 32'({swapped, sticky, sign_big, sign_small}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_back", 32'(in_ready), 32'd1);
    repeat (6) @(negedge clk);

    // Random pairs with random backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 3 == 0) rb[14:10] = 5'(ra[14:10] + 5'($urandom_range(0, 3)));
      if (i % 7 == 0) rb[14:10] = 5'd0;
      send(ra, rb);
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
